reg_wb_ctrl: RTL

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

---
 rtl/reg_wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/reg_wb_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg -- shared types and defaults for the register writeback controller.
//   XLEN_DEF / AW_DEF : default register data / address widths
//   wb_req_t          : one queued writeback request {addr, data}
//   wb_src_e          : writeback source identifier, also used as last-grant state
package reg_wb_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned AW_DEF   = 5;

  typedef struct packed {
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- single-clock FIFO of writeback requests, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, rst          : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_wdata   : enqueue request (ignored while full)
//   i_pop             : dequeue head (ignored while empty)
//   o_rdata           : current head entry, valid while !o_empty
//   o_full, o_empty   : occupancy flags
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = wb_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_wdata,
  input  logic i_pop,
  output T     o_rdata,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl -- merges ALU and load-unit writeback requests into the single
// register-file write port.
// Each source has its own wb_fifo; a round-robin arbiter pops one head per cycle
// into the output register, so wr_en follows a pop by one cycle.
// Ports:
//   clk, rst                                 : clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_addr/alu_data    : ALU writeback request channel
//   mem_valid/mem_ready/mem_addr/mem_data    : load-unit writeback request channel
//   wr_en/wr_addr/wr_data                    : register-file write port (never stalled)
//   pending                                  : number of queued, not yet popped entries
//   rd_addr1/rd_addr2                        : register-file read addresses
//   byp_hit1/2, byp_data1/2                  : forwarding of the write in flight
// Build option:
//   REG_WB_BYPASS_EN : when defined, byp_* forward wr_data on an address match;
//                      otherwise byp_* are tied to 0 and rd_addr1/2 are unused.
module reg_wb_ctrl
  import reg_wb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [AW-1:0]                   alu_addr,
  input  logic [XLEN-1:0]                 alu_data,
  input  logic                            mem_valid,
  output logic                            mem_ready,
  input  logic [AW-1:0]                   mem_addr,
  input  logic [XLEN-1:0]                 mem_data,
  output logic                            wr_en,
  output logic [AW-1:0]                   wr_addr,
  output logic [XLEN-1:0]                 wr_data,
  output logic [$clog2(2*DEPTH+2)-1:0]    pending,
  input  logic [AW-1:0]                   rd_addr1,
  input  logic [AW-1:0]                   rd_addr2,
  output logic                            byp_hit1,
  output logic                            byp_hit2,
  output logic [XLEN-1:0]                 byp_data1,
  output logic [XLEN-1:0]                 byp_data2
);

  localparam int unsigned PW = $clog2(2*DEPTH+2);

  // Same layout as wb_req_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } req_t;

  req_t            w_alu_req;
  req_t            w_mem_req;
  req_t            w_alu_head;
  req_t            w_mem_head;
  req_t            w_head;
  logic            w_alu_full;
  logic            w_alu_empty;
  logic            w_mem_full;
  logic            w_mem_empty;
  logic            w_push_alu;
  logic            w_push_mem;
  logic            w_pop_alu;
  logic            w_pop_mem;
  logic            w_pop_any;
  wb_src_e         w_grant;

  wb_src_e         r_last;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [XLEN-1:0] r_wr_data;
  logic [PW-1:0]   r_pending;

  // ---------------------------------------------------------------------------
  // Request acceptance. A full queue stays not-ready even when it is being
  // popped in the same cycle. Address-0 requests complete the handshake but
  // are dropped here, so they never occupy a queue slot or count as pending.
  // ---------------------------------------------------------------------------
  assign alu_ready  = !w_alu_full && !rst;
  assign mem_ready  = !w_mem_full && !rst;
  assign w_push_alu = alu_valid && alu_ready && (alu_addr != '0);
  assign w_push_mem = mem_valid && mem_ready && (mem_addr != '0);

  assign w_alu_req = '{addr: alu_addr, data: alu_data};
  assign w_mem_req = '{addr: mem_addr, data: mem_data};

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_alu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_alu),
    .i_wdata (w_alu_req),
    .i_pop   (w_pop_alu),
    .o_rdata (w_alu_head),
    .o_full  (w_alu_full),
    .o_empty (w_alu_empty)
  );

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_mem_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_mem),
    .i_wdata (w_mem_req),
    .i_pop   (w_pop_mem),
    .o_rdata (w_mem_head),
    .o_full  (w_mem_full),
    .o_empty (w_mem_empty)
  );

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: on contention the source not granted last wins;
  // a lone valid head always wins. One pop per cycle whenever anything is queued.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pop_alu = 1'b0;
    w_pop_mem = 1'b0;
    w_grant   = r_last;
    w_head    = w_alu_head;
    if (!w_alu_empty && !w_mem_empty) begin
      if (r_last == SRC_ALU) begin
        w_pop_mem = 1'b1;
        w_grant   = SRC_MEM;
        w_head    = w_mem_head;
      end else begin
        w_pop_alu = 1'b1;
        w_grant   = SRC_ALU;
        w_head    = w_alu_head;
      end
    end else if (!w_alu_empty) begin
      w_pop_alu = 1'b1;
      w_grant   = SRC_ALU;
      w_head    = w_alu_head;
    end else if (!w_mem_empty) begin
      w_pop_mem = 1'b1;
      w_grant   = SRC_MEM;
      w_head    = w_mem_head;
    end
  end

  assign w_pop_any = w_pop_alu || w_pop_mem;

  // ---------------------------------------------------------------------------
  // Output register, last-grant state and pending count.
  // Address/data only load on a pop so they hold while wr_en is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= SRC_ALU;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_pending <= '0;
    end else begin
      r_wr_en   <= w_pop_any;
      if (w_pop_any) begin
        r_last    <= w_grant;
        r_wr_addr <= w_head.addr;
        r_wr_data <= w_head.data;
      end
      r_pending <= r_pending + PW'(w_push_alu) + PW'(w_push_mem) - PW'(w_pop_any);
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign pending = r_pending;

  // ---------------------------------------------------------------------------
  // Bypass of the write currently on the register-file port.
  // ---------------------------------------------------------------------------
`ifdef REG_WB_BYPASS_EN
  assign byp_hit1  = r_wr_en && (r_wr_addr == rd_addr1) && (rd_addr1 != '0);
  assign byp_hit2  = r_wr_en && (r_wr_addr == rd_addr2) && (rd_addr2 != '0);
  assign byp_data1 = byp_hit1 ? r_wr_data : '0;
  assign byp_data2 = byp_hit2 ? r_wr_data : '0;
`else
  logic w_unused;
  assign w_unused  = ^{rd_addr1, rd_addr2};
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule
